// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the ALU and by the control unit.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_And = 3'd0,
    ALU_Add = 3'd1,
    ALU_Sub = 3'd2,
    ALU_SLL = 3'd3,
    ALU_SLR = 3'd4
  } alu_op_t;

  // True for the ops that go through the shared adder/subtractor.
  function automatic logic uses_adder(input logic [ALU_OP_W-1:0] op);
    logic hit;
    case (op)
      3'd1:    hit = 1'b1;
      3'd2:    hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage : alu_pkg

// File: rtl/alu_datapath.sv
// Combinational ALU datapath: op decode, shared add/sub, shifter and next-flag generation.
// Optional ALU_OVERFLOW_EN adds a signed-overflow output for ADD/SUB.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                zero_o,
`ifdef ALU_OVERFLOW_EN
  output logic                overflow_o,
`endif
  output logic                negative_o
);

  alu_op_t              op_s;
  logic                 is_sub_s;
  logic [WIDTH-1:0]     b_eff_s;
  logic [WIDTH-1:0]     sum_s;
  logic [SHAMT_W-1:0]   shamt_s;
  logic [WIDTH-1:0]     sll_s;
  logic [WIDTH-1:0]     slr_s;
  logic [WIDTH-1:0]     result_s;

  assign op_s    = alu_op_t'(op_i);
  assign shamt_s = b_i[SHAMT_W-1:0];

  // Shared adder: subtraction is A + ~B + 1, so one carry chain serves both ops.
  always_comb begin
    is_sub_s = 1'b0;
    if (op_s == ALU_Sub) begin
      is_sub_s = 1'b1;
    end else begin
      is_sub_s = 1'b0;
    end
    b_eff_s = is_sub_s ? ~b_i : b_i;
    sum_s   = a_i + b_eff_s + {{(WIDTH-1){1'b0}}, is_sub_s};
  end

  // Logical shifters; upper bits of B never reach the shift amount.
  always_comb begin
    sll_s = a_i << shamt_s;
    slr_s = a_i >> shamt_s;
  end

  // Result select; reserved codes yield a defined zero.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (op_s)
      ALU_And: result_s = a_i & b_i;
      ALU_Add: result_s = sum_s;
      ALU_Sub: result_s = sum_s;
      ALU_SLL: result_s = sll_s;
      ALU_SLR: result_s = slr_s;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state flags derived from the selected result.
  always_comb begin
    result_o   = result_s;
    zero_o     = (result_s == {WIDTH{1'b0}});
    negative_o = result_s[WIDTH-1];
  end

`ifdef ALU_OVERFLOW_EN
  // With B already inverted for SUB, both cases reduce to: same-sign inputs, differing result sign.
  always_comb begin
    overflow_o = 1'b0;
    if (uses_adder(op_i)) begin
      overflow_o = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
    end else begin
      overflow_o = 1'b0;
    end
  end
`endif

endmodule : alu_datapath

// File: rtl/alu.sv
// Registered execute-stage ALU: result and flags captured every rising edge, async active-low reset.
// Optional ALU_OVERFLOW_EN adds the registered flag_overflow output.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] sig_alu_op,
  output logic [WIDTH-1:0]    Output,
  output logic                flag_zero,
`ifdef ALU_OVERFLOW_EN
  output logic                flag_overflow,
`endif
  output logic                flag_negative
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_d;
  logic             zero_q;
  logic             negative_d;
  logic             negative_q;
`ifdef ALU_OVERFLOW_EN
  logic             overflow_d;
  logic             overflow_q;
`endif

  alu_datapath #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_datapath (
    .a_i        (A),
    .b_i        (B),
    .op_i       (sig_alu_op),
    .result_o   (result_d),
    .zero_o     (zero_d),
`ifdef ALU_OVERFLOW_EN
    .overflow_o (overflow_d),
`endif
    .negative_o (negative_d)
  );

  // Result and flags share one edge so they always describe the same operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow flag register, same timing as the other flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign flag_overflow = overflow_q;
`endif

  assign Output        = result_q;
  assign flag_zero     = zero_q;
  assign flag_negative = negative_q;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized ops against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    sig_alu_op;
  logic [W-1:0]  Output;
  logic          flag_zero;
  logic          flag_negative;
`ifdef ALU_OVERFLOW_EN
  logic          flag_overflow;
`endif

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .A             (A),
    .B             (B),
    .sig_alu_op    (sig_alu_op),
    .Output        (Output),
    .flag_zero     (flag_zero),
`ifdef ALU_OVERFLOW_EN
    .flag_overflow (flag_overflow),
`endif
    .flag_negative (flag_negative)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic logic [W-1:0] model_result(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua  = a;
    longint unsigned ub  = b;
    longint unsigned pw  = 1;
    longint unsigned mod = 64'h1_0000_0000;
    int sh = int'(ub % 32);
    for (int k = 0; k < sh; k++) pw = pw * 2;
    case (op)
      0: return a & b;
      1: return W'((ua + ub) % mod);
      2: return W'((ua + mod - ub) % mod);
      3: return W'((ua * pw) % mod);
      4: return W'(ua / pw);
      default: return '0;
    endcase
  endfunction

  function automatic logic model_overflow(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    if (op == 1) r = sa + sb;
    else if (op == 2) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic drive(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    sig_alu_op = 3'(op);
    A          = a;
    B          = b;
  endtask

  // Apply one op, wait one edge, compare against fixed expectations.
  task automatic directed(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic ez, input logic en);
    drive(op, a, b);
    @(posedge clock);
    #1;
    check({tag, ".res"}, Output, exp);
    check({tag, ".z"},   W'(flag_zero), W'(ez));
    check({tag, ".n"},   W'(flag_negative), W'(en));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb, er;
    int rop;

    reset = 1'b0;
    drive(0, 32'd0, 32'd0);
    #3;
    check("rst.res", Output, 32'd0);
    check("rst.z",   W'(flag_zero), 32'd0);
    check("rst.n",   W'(flag_negative), 32'd0);
    #9 reset = 1'b1;
    @(posedge clock);
    #1;

    // Asynchronous reset in the middle of an ADD stream.
    directed("pre_rst_add", 1, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_rst.res", Output, 32'd0);
    check("async_rst.z",   W'(flag_zero), 32'd0);
    check("async_rst.n",   W'(flag_negative), 32'd0);
    @(posedge clock);
    #1;
    check("rst_hold.res", Output, 32'd0);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst.res", Output, 32'd30);
    check("post_rst.z",   W'(flag_zero), 32'd0);
    check("post_rst.n",   W'(flag_negative), 32'd0);

    directed("add",       1, 32'd10,          32'd20,     32'd30,          1'b0, 1'b0);
    directed("sub",       2, 32'd30,          32'd20,     32'd10,          1'b0, 1'b0);
    directed("and",       0, 32'h0F0F,        32'h0FFF,   32'h0F0F,        1'b0, 1'b0);
    directed("sll",       3, 32'h0F0F,        32'd4,      32'hF0F0,        1'b0, 1'b0);
    directed("slr",       4, 32'h0F0F,        32'd4,      32'h00F0,        1'b0, 1'b0);
    directed("sub_zero",  2, 32'd50,          32'd50,     32'd0,           1'b1, 1'b0);
    directed("sub_neg",   2, 32'd50,          32'd100,    32'hFFFF_FFCE,   1'b0, 1'b1);
    directed("add_wrap",  1, 32'hFFFF_FFFF,   32'd1,      32'd0,           1'b1, 1'b0);
    directed("sll_31",    3, 32'd1,           32'd31,     32'h8000_0000,   1'b0, 1'b1);
    directed("sll_b32",   3, 32'h1234_5678,   32'd32,     32'h1234_5678,   1'b0, 1'b0);
    directed("sll_b33",   3, 32'h1234_5678,   32'd33,     32'h2468_ACF0,   1'b0, 1'b0);
    directed("slr_31",    4, 32'h8000_0000,   32'd31,     32'd1,           1'b0, 1'b0);
    directed("rsvd6",     6, 32'hDEAD_BEEF,   32'h1234,   32'd0,           1'b1, 1'b0);
    directed("rsvd5",     5, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'd0,        1'b1, 1'b0);
    directed("rsvd7",     7, 32'h8000_0000,   32'd1,      32'd0,           1'b1, 1'b0);

`ifdef ALU_OVERFLOW_EN
    directed("ovf_add", 1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    check("ovf_add.v", W'(flag_overflow), 32'd1);
    directed("ovf_sub", 2, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    check("ovf_sub.v", W'(flag_overflow), 32'd1);
    directed("ovf_none", 1, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    check("ovf_none.v", W'(flag_overflow), 32'd0);
`endif

    // Randomized back-to-back ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = int'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 70)) : pick_operand();
      er  = model_result(rop, ra, rb);
      drive(rop, ra, rb);
      @(posedge clock);
      #1;
      check($sformatf("rnd%0d.op%0d.res", i, rop), Output, er);
      check($sformatf("rnd%0d.z", i), W'(flag_zero), W'(er == 32'd0));
      check($sformatf("rnd%0d.n", i), W'(flag_negative), W'(er[W-1]));
`ifdef ALU_OVERFLOW_EN
      check($sformatf("rnd%0d.v", i), W'(flag_overflow), W'(model_overflow(rop, ra, rb)));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule : tb_alu
